// File: rtl/sdf_bf_stage_pkg.sv
// Shared definitions for the radix-2 SDF butterfly stage: data width and FSM states.
// Legal feedback depths are 1, 2, 4 and 8 complex samples.
package sdf_bf_stage_pkg;

    localparam int CALC_TEMP_BUS = 16;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_BFLY  = 2'd1,
        ST_FILL  = 2'd2
    } bf_state_e;

endpackage

// File: rtl/sdf_delay_line.sv
// Feedback line of the SDF stage: DEPTH-entry shift register of packed {re, im} words.
// Entries move one place only on an accepted sample; head_o is the oldest entry.
module sdf_delay_line #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          shift_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] head_o
);

    logic [DW-1:0] line_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                line_q[k] <= '0;
            end
        end else if (shift_i) begin
            line_q[0] <= din_i;
            for (int k = 1; k < DEPTH; k++) begin
                line_q[k] <= line_q[k-1];
            end
        end
    end

    assign head_o = line_q[DEPTH-1];

endmodule

// File: rtl/sdf_bf_stage.sv
// Radix-2 single-delay-feedback DIF butterfly stage: sample counter, PRIME/BFLY/FILL
// control and the halving add/sub datapath with registered outputs.
module sdf_bf_stage
    import sdf_bf_stage_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = CALC_TEMP_BUS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_diff,
    output logic                    frame_start,
    output bf_state_e               dbg_state_o
);

    localparam int CW = (DEPTH > 1) ? $clog2(2 * DEPTH) : 1;
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MID       = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST      = CW'(2 * DEPTH - 1);

    bf_state_e               state_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    out_valid_q, out_diff_q, frame_start_q;
    logic signed [WIDTH-1:0] out_re_q, out_im_q;

    logic [2*WIDTH-1:0]      head, push_d;
    logic [WIDTH-1:0]        head_re, head_im;
    logic [WIDTH:0]          sum_re, sum_im, dif_re, dif_im;

    assign head_re = head[2*WIDTH-1:WIDTH];
    assign head_im = head[WIDTH-1:0];

    // One guard bit keeps the sum exact; dropping bit 0 is the floor-halving shift.
    assign sum_re = {head_re[WIDTH-1], head_re} + {in_re[WIDTH-1], in_re};
    assign sum_im = {head_im[WIDTH-1], head_im} + {in_im[WIDTH-1], in_im};
    assign dif_re = {head_re[WIDTH-1], head_re} - {in_re[WIDTH-1], in_re};
    assign dif_im = {head_im[WIDTH-1], head_im} - {in_im[WIDTH-1], in_im};

    always_comb begin
        push_d = {in_re, in_im};
        if (state_q == ST_BFLY) begin
            push_d = {dif_re[WIDTH:1], dif_im[WIDTH:1]};
        end
    end

    assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    sdf_delay_line #(
        .DEPTH (DEPTH),
        .DW    (2 * WIDTH)
    ) u_line (
        .clk_i   (clk),
        .rst_i   (reset),
        .shift_i (in_valid),
        .din_i   (push_d),
        .head_o  (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_PRIME;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            out_diff_q    <= 1'b0;
            out_re_q      <= '0;
            out_im_q      <= '0;
        end else if (in_valid) begin
            cnt_q <= cnt_d;
            case (state_q)
                ST_PRIME: begin
                    out_valid_q   <= 1'b0;
                    frame_start_q <= 1'b0;
                    if (cnt_q == CNT_HALF_LAST) state_q <= ST_BFLY;
                end
                ST_BFLY: begin
                    out_valid_q   <= 1'b1;
                    frame_start_q <= (cnt_q == CNT_MID);
                    out_diff_q    <= 1'b0;
                    out_re_q      <= sum_re[WIDTH:1];
                    out_im_q      <= sum_im[WIDTH:1];
                    if (cnt_q == CNT_LAST) state_q <= ST_FILL;
                end
                ST_FILL: begin
                    out_valid_q   <= 1'b1;
                    frame_start_q <= (cnt_q == '0);
                    out_diff_q    <= 1'b1;
                    out_re_q      <= head_re;
                    out_im_q      <= head_im;
                    if (cnt_q == CNT_HALF_LAST) state_q <= ST_BFLY;
                end
                default: begin
                    out_valid_q   <= 1'b0;
                    frame_start_q <= 1'b0;
                    state_q       <= ST_PRIME;
                end
            endcase
        end else begin
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign out_diff    = out_diff_q;
    assign out_re      = out_re_q;
    assign out_im      = out_im_q;
    assign dbg_state_o = state_q;

endmodule
